pwm_duty_sweep_master: RTL
==========================

Name: pwm_duty_sweep_master

Overview:
- Avalon-MM initiator that drives the 8-bit PWM output register through its slave port, the other end of that memory-mapped interface.
- On every duty tick it computes the next duty value on a triangle ramp and writes it to register offset 0.
- It then reads the register back and flags any mismatch.
- It sits in the Qsys fabric beside the Nios master so the PWM can sweep autonomously for bring-up and demo builds.

Parameters:
- DATA_W, 8, width of the duty value (matches the PWM output register width).
- TICK_DIV, 1000, clk cycles between duty ticks (≥ 8).
- REG_ADDR, 0, word offset of the PWM output register.
- TIMEOUT, 255, maximum cycles a single transfer may wait on avm_waitrequest.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = ramp running; 0 = finish the current transfer, then idle.
- step  in  DATA_W  ramp increment per tick (0 = hold the value).
- min_duty  in  DATA_W  lower ramp bound.
- max_duty  in  DATA_W  upper ramp bound (must be ≥ min_duty).
- avm_address  out  2  word address; always REG_ADDR.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_writedata  out  32  {(32-DATA_W) zeros, duty}.
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest.
- avm_waitrequest  in  1  slave stall.
- duty  out  DATA_W  last value successfully written.
- busy  out  1  FSM not in IDLE.
- mismatch  out  1  sticky: a readback differed from the written value.
- timeout  out  1  sticky: a transfer was aborted after TIMEOUT cycles.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; tick counter, duty, ramp value and direction go to 0/up.
  - All outputs go to 0 the next edge, including avm_write/avm_read, even mid-transfer.
  - All sticky flags are cleared; they clear only on reset.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1 and wraps to 0.
  - tick=1 on the cycle the count equals TICK_DIV-1.
  - enable=0 holds the count at 0.
- Ramp, computed in DATA_W+1 bits:
  - Up direction: nxt = cur+step. If nxt ≥ max_duty, nxt = max_duty and the direction flips to down.
  - Down direction: if cur < min_duty+step (including underflow), nxt = min_duty and the direction flips to up; else nxt = cur-step.
  - The first tick after reset starts from cur = min_duty.
  - cur outside [min,max] (bounds changed at run time) is clamped into range on the next computation.
- FSM states IDLE, WRITE, READ, CHECK:
  - IDLE: on tick, latch nxt into wr_val and go to WRITE. avm_write asserts on the next cycle, so latency from tick to avm_write is 1 cycle.
  - WRITE: hold avm_write=1, avm_address and avm_writedata stable until a cycle with avm_waitrequest=0. On that cycle the transfer completes, duty <= wr_val, cur <= wr_val, and the FSM goes to READ.
  - READ: hold avm_read=1 until avm_waitrequest=0; capture avm_readdata on that cycle and go to CHECK.
  - CHECK (1 cycle): set mismatch if readdata ≠ zero-extended wr_val, which also checks that the upper 24 bits are 0. Then return to IDLE.
- avm_write and avm_read are never asserted in the same cycle.
- Timeout:
  - A wait counter is reset on entry to WRITE and READ.
  - If it reaches TIMEOUT with waitrequest still 1: drop the request, set timeout, return to IDLE.
  - An aborted write leaves duty and cur unchanged.
- Tick in a non-IDLE state: set overrun; the tick is dropped, not queued.
- enable falling mid-transfer: the transfer and CHECK complete normally; no new tick is generated.
- step=0: writes repeat the same value; the direction never flips.
- min_duty = max_duty: every write carries that value.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum (IDLE/WRITE/READ/CHECK);
  - PWM_REG_ADDR = 0 and PWM_DATA_W = 8;
  - the Avalon data width constant 32.
- One sub-module, pwm_ramp_gen: combinational next-value/direction logic plus the registered cur/dir. The master FSM instantiates it and pulses its advance input on write completion.

Test Plan:
- Reset / idle:
  - Stimulus: reset high 3 cycles, enable=0.
  - Response: all outputs 0; no avm_write/avm_read for 5·TICK_DIV cycles.
- Basic ramp:
  - Stimulus: TICK_DIV=16, step=64, min=0, max=200, zero-wait slave model.
  - Response: write sequence 64,128,192,200,136,72,8,0,64; each readback equal; mismatch=0.
- Waitrequest stall:
  - Stimulus: slave holds waitrequest 5 cycles on write and 3 cycles on read.
  - Response: avm_write high exactly 6 cycles with stable writedata; avm_read high 4 cycles; duty updates on the write-completion edge.
- Timeout:
  - Stimulus: TIMEOUT=10, waitrequest stuck at 1.
  - Response: avm_write drops after 10 wait cycles; timeout=1; duty unchanged; the next tick retries the same value.
- Mismatch and overrun:
  - Stimulus: slave returns readdata=0x100 for a write of 0x00.
  - Response: mismatch=1.
  - Stimulus: TICK_DIV=8 with 6-cycle write stalls.
  - Response: overrun=1.
- Reset mid-transfer:
  - Stimulus: assert reset while avm_write=1 and waitrequest=1.
  - Response: avm_write=0 on the next edge; FSM IDLE; sticky flags cleared.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty sweep master and its ramp generator.
package pwm_pkg;

  localparam int PWM_REG_ADDR = 0;
  localparam int PWM_DATA_W   = 8;
  localparam int AVM_DATA_W   = 32;
  localparam int AVM_ADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_duty_sweep_master_if.sv
// Avalon-MM link between the duty sweep master and the PWM output register slave.
interface pwm_duty_sweep_master_if;
  import pwm_pkg::*;

  logic [AVM_ADDR_W-1:0] address;
  logic                  write;
  logic                  read;
  logic [AVM_DATA_W-1:0] writedata;
  logic [AVM_DATA_W-1:0] readdata;
  logic                  waitrequest;

  modport master (
    output address, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/pwm_ramp_gen.sv
// Triangle ramp generator: registered current value/direction plus the
// combinational next value, clamped into [min_duty, max_duty].
module pwm_ramp_gen
  import pwm_pkg::*;
#(
  parameter int DATA_W = PWM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] min_duty,
  input  logic [DATA_W-1:0] max_duty,
  input  logic              advance,
  input  logic [DATA_W-1:0] load_val,
  input  dir_t              load_dir,
  output logic [DATA_W-1:0] nxt_val,
  output dir_t              nxt_dir
);

  logic [DATA_W-1:0] cur;
  dir_t              dir;
  logic [DATA_W-1:0] base;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   lower;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      dir <= DIR_UP;
    end else if (advance) begin
      cur <= load_val;
      dir <= load_dir;
    end
  end

  // A zero step holds the clamped value and never turns the ramp around.
  always_comb begin
    base = cur;
    if (cur < min_duty)
      base = min_duty;
    else if (cur > max_duty)
      base = max_duty;
    sum     = {1'b0, base} + {1'b0, step};
    lower   = {1'b0, min_duty} + {1'b0, step};
    nxt_val = base;
    nxt_dir = dir;
    if (step != '0) begin
      if (dir == DIR_UP) begin
        if (sum >= {1'b0, max_duty}) begin
          nxt_val = max_duty;
          nxt_dir = DIR_DOWN;
        end else begin
          nxt_val = sum[DATA_W-1:0];
        end
      end else if ({1'b0, base} < lower) begin
        nxt_val = min_duty;
        nxt_dir = DIR_UP;
      end else begin
        nxt_val = base - step;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sweep_master.sv
// Avalon-MM initiator that sweeps the PWM duty register on a triangle ramp,
// reading each write back and flagging mismatches, stalls and overruns.
module pwm_duty_sweep_master
  import pwm_pkg::*;
#(
  parameter int DATA_W   = PWM_DATA_W,
  parameter int TICK_DIV = 1000,
  parameter int REG_ADDR = PWM_REG_ADDR,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       step,
  input  logic [DATA_W-1:0]       min_duty,
  input  logic [DATA_W-1:0]       max_duty,
  pwm_duty_sweep_master_if.master avm,
  output logic [DATA_W-1:0]       duty,
  output logic                    busy,
  output logic                    mismatch,
  output logic                    timeout,
  output logic                    overrun
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam int PAD_W = AVM_DATA_W - DATA_W;

  state_t                state;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_W-1:0]     wr_val;
  dir_t                  wr_dir;
  logic [AVM_DATA_W-1:0] rd_data;
  logic [DATA_W-1:0]     nxt_val;
  dir_t                  nxt_dir;
  logic                  advance;

  assign avm.address = AVM_ADDR_W'(REG_ADDR);
  assign tick        = enable && (tick_cnt == CNT_LAST);
  assign advance     = (state == WRITE) && !avm.waitrequest;

  always_ff @(posedge clk) begin
    if (reset || !enable || tick_cnt == CNT_LAST)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  pwm_ramp_gen #(
    .DATA_W (DATA_W)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .min_duty (min_duty),
    .max_duty (max_duty),
    .advance  (advance),
    .load_val (wr_val),
    .load_dir (wr_dir),
    .nxt_val  (nxt_val),
    .nxt_dir  (nxt_dir)
  );

  // The wait counter counts stalled cycles; the request is dropped on the TIMEOUT-th one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wr_val        <= '0;
      wr_dir        <= DIR_UP;
      rd_data       <= '0;
      avm.write     <= 1'b0;
      avm.read      <= 1'b0;
      avm.writedata <= '0;
      duty          <= '0;
      busy          <= 1'b0;
      mismatch      <= 1'b0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (tick && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick) begin
            wr_val        <= nxt_val;
            wr_dir        <= nxt_dir;
            avm.writedata <= {{PAD_W{1'b0}}, nxt_val};
            avm.write     <= 1'b1;
            wait_cnt      <= '0;
            busy          <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (!avm.waitrequest) begin
            avm.write <= 1'b0;
            avm.read  <= 1'b1;
            duty      <= wr_val;
            wait_cnt  <= '0;
            state     <= READ;
          end else if (wait_cnt == WAIT_LAST) begin
            avm.write <= 1'b0;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        READ: begin
          if (!avm.waitrequest) begin
            avm.read <= 1'b0;
            rd_data  <= avm.readdata;
            state    <= CHECK;
          end else if (wait_cnt == WAIT_LAST) begin
            avm.read <= 1'b0;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (rd_data != {{PAD_W{1'b0}}, wr_val})
            mismatch <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
